// File: rtl/stream_pattern_source.sv
// Framed byte-stream generator: SYNC0, SYNC1, SEQ, counting payload, XOR checksum,
// then an optional idle gap. Valid/ready handshake with fully registered tx_vld/tx_byte.
module stream_pattern_source #(
  parameter int          FRAME_LEN  = 9,
  parameter int          GAP_CYCLES = 4999987,
  parameter logic [7:0]  SYNC0      = 8'hA5,
  parameter logic [7:0]  SYNC1      = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tx_rdy,
  output logic       tx_vld,
  output logic [7:0] tx_byte,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] seq
);

  typedef enum logic [2:0] {IDLE, S_SYNC0, S_SYNC1, S_SEQ, S_PAY, S_CSUM, GAP} state_t;

  localparam logic [7:0]  PAY_LAST = 8'(FRAME_LEN - 1);
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [23:0] GAP_LAST = HAS_GAP ? 24'(GAP_CYCLES - 1) : 24'd0;

  state_t      state_reg, state_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  seq_reg, seq_next;
  logic [7:0]  csum_reg, csum_next;
  logic [23:0] gap_reg, gap_next;
  logic        tx_vld_reg, tx_vld_next;
  logic [7:0]  tx_byte_reg, tx_byte_next;
  logic        xfer;

  assign xfer = tx_vld_reg & tx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= 8'd0;
      seq_reg     <= 8'd0;
      csum_reg    <= 8'd0;
      gap_reg     <= 24'd0;
      tx_vld_reg  <= 1'b0;
      tx_byte_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      seq_reg     <= seq_next;
      csum_reg    <= csum_next;
      gap_reg     <= gap_next;
      tx_vld_reg  <= tx_vld_next;
      tx_byte_reg <= tx_byte_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    seq_next   = seq_reg;
    csum_next  = csum_reg;
    gap_next   = gap_reg;

    case (state_reg)
      IDLE: if (enable) state_next = S_SYNC0;
      S_SYNC0: if (xfer) state_next = S_SYNC1;
      S_SYNC1: if (xfer) state_next = S_SEQ;
      S_SEQ: if (xfer) begin
        state_next = S_PAY;
        idx_next   = 8'd0;
        csum_next  = seq_reg;
      end
      S_PAY: if (xfer) begin
        csum_next = csum_reg ^ (seq_reg + idx_reg);
        if (idx_reg == PAY_LAST) begin
          state_next = S_CSUM;
          idx_next   = 8'd0;
        end else begin
          idx_next = idx_reg + 8'd1;
        end
      end
      S_CSUM: if (xfer) begin
        seq_next = seq_reg + 8'd1;
        if (HAS_GAP) begin
          state_next = GAP;
          gap_next   = 24'd0;
        end else begin
          state_next = enable ? S_SYNC0 : IDLE;
        end
      end
      GAP: begin
        // enable is only consulted once the full gap has elapsed
        if (gap_reg == GAP_LAST) begin
          state_next = enable ? S_SYNC0 : IDLE;
          gap_next   = 24'd0;
        end else begin
          gap_next = gap_reg + 24'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output registers are loaded from the next-state view so they line up with state_reg.
  always_comb begin
    tx_vld_next  = 1'b0;
    tx_byte_next = 8'd0;
    case (state_next)
      S_SYNC0: begin tx_vld_next = 1'b1; tx_byte_next = SYNC0; end
      S_SYNC1: begin tx_vld_next = 1'b1; tx_byte_next = SYNC1; end
      S_SEQ:   begin tx_vld_next = 1'b1; tx_byte_next = seq_next; end
      S_PAY:   begin tx_vld_next = 1'b1; tx_byte_next = seq_next + idx_next; end
      S_CSUM:  begin tx_vld_next = 1'b1; tx_byte_next = csum_next; end
      default: begin tx_vld_next = 1'b0; tx_byte_next = 8'd0; end
    endcase
  end

  assign tx_vld      = tx_vld_reg;
  assign tx_byte     = tx_byte_reg;
  assign frame_start = (state_reg == S_SYNC0) & xfer;
  assign frame_done  = (state_reg == S_CSUM) & xfer;
  assign busy        = (state_reg != IDLE);
  assign seq         = seq_reg;

endmodule

// File: tb/tb_stream_pattern_source.sv
// Bench for stream_pattern_source: three instances (len3/gap2, len3/gap0, len1/gap0)
// checked against a byte scoreboard fed from constant tables and a small frame model.
module tb_stream_pattern_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       en   [3];
  logic       rdy  [3];
  logic       vld  [3];
  logic [7:0] byt  [3];
  logic       fs   [3];
  logic       fd   [3];
  logic       bsy  [3];
  logic [7:0] sq   [3];

  always #5 clk = ~clk;

  stream_pattern_source #(.FRAME_LEN(3), .GAP_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .enable(en[0]), .tx_rdy(rdy[0]), .tx_vld(vld[0]), .tx_byte(byt[0]),
    .frame_start(fs[0]), .frame_done(fd[0]), .busy(bsy[0]), .seq(sq[0]));

  stream_pattern_source #(.FRAME_LEN(3), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .enable(en[1]), .tx_rdy(rdy[1]), .tx_vld(vld[1]), .tx_byte(byt[1]),
    .frame_start(fs[1]), .frame_done(fd[1]), .busy(bsy[1]), .seq(sq[1]));

  stream_pattern_source #(.FRAME_LEN(1), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .enable(en[2]), .tx_rdy(rdy[2]), .tx_vld(vld[2]), .tx_byte(byt[2]),
    .frame_start(fs[2]), .frame_done(fd[2]), .busy(bsy[2]), .seq(sq[2]));

  typedef struct { logic [7:0] b; logic st; logic dn; } exp_t;
  typedef struct {
    bit              rdy_rand;
    int              exp_idle;
    logic [7:0]      exp_seq;
    logic [0:6][7:0] bytes;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[4];
  int         total = 0;
  int         bad   = 0;
  int         n_xfer, n_idle, n_coinc;
  bit         hold_pend;
  logic [7:0] hold_byte;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin en[i] = 1'b0; rdy[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_pend = 1'b0;
    sb.delete();
    n_xfer = 0; n_idle = 0; n_coinc = 0;
  endtask

  task automatic push_vec(input int v);
    for (int j = 0; j < 7; j++)
      sb.push_back('{b: vecs[v].bytes[j], st: (j == 0), dn: (j == 6)});
  endtask

  task automatic push_model(input logic [7:0] s, input int len);
    logic [7:0] c, p;
    sb.push_back('{b: 8'hA5, st: 1'b1, dn: 1'b0});
    sb.push_back('{b: 8'h5A, st: 1'b0, dn: 1'b0});
    sb.push_back('{b: s, st: 1'b0, dn: 1'b0});
    c = s;
    for (int i = 0; i < len; i++) begin
      p = s + 8'(i);
      c = c ^ p;
      sb.push_back('{b: p, st: 1'b0, dn: 1'b0});
    end
    sb.push_back('{b: c, st: 1'b0, dn: 1'b1});
  endtask

  // One cycle: sample at negedge, then advance to just past the next posedge.
  task automatic cyc(input int k);
    exp_t e;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_vld", 32'(vld[k]), 32'd1);
      chk("hold_byte", 32'(byt[k]), 32'(hold_byte));
    end
    if (vld[k] && rdy[k]) begin
      n_xfer++;
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 32'(byt[k]), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        $display("xfer inst=%0d byte=%02h exp=%02h start=%0b done=%0b", k, byt[k], e.b, fs[k], fd[k]);
        chk("byte", 32'(byt[k]), 32'(e.b));
        chk("frame_start", 32'(fs[k]), 32'(e.st));
        chk("frame_done", 32'(fd[k]), 32'(e.dn));
      end
    end else begin
      chk("pulse_idle", 32'({fs[k], fd[k]}), 32'd0);
    end
    if (!vld[k]) n_idle++;
    if (fs[k] && fd[k]) n_coinc++;
    hold_pend = vld[k] && !rdy[k];
    hold_byte = byt[k];
    @(posedge clk);
    #1;
  endtask

  task automatic run_frames(input int k, input bit rnd, input int drop_at, input int limit);
    int n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      if (drop_at >= 0 && sb.size() <= drop_at) en[k] = 1'b0;
      rdy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(k);
      n++;
    end
    if (sb.size() > 0) begin
      chk("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    vecs[0] = '{rdy_rand: 1'b0, exp_idle: 1, exp_seq: 8'h01,
                bytes: {8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03}};
    vecs[1] = '{rdy_rand: 1'b0, exp_idle: 2, exp_seq: 8'h02,
                bytes: {8'hA5, 8'h5A, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01}};
    vecs[2] = '{rdy_rand: 1'b1, exp_idle: 2, exp_seq: 8'h03,
                bytes: {8'hA5, 8'h5A, 8'h02, 8'h02, 8'h03, 8'h04, 8'h07}};
    vecs[3] = '{rdy_rand: 1'b1, exp_idle: 2, exp_seq: 8'h04,
                bytes: {8'hA5, 8'h5A, 8'h03, 8'h03, 8'h04, 8'h05, 8'h01}};

    // Reset state of all instances
    do_reset();
    for (int k = 0; k < 3; k++)
      chk("reset_state", 32'({vld[k], byt[k], fs[k], fd[k], bsy[k], sq[k]}), 32'd0);

    // Table: consecutive frames on the gapped instance, fixed then random ready
    en[0] = 1'b1;
    for (int v = 0; v < 4; v++) begin
      n_idle = 0;
      push_vec(v);
      run_frames(0, vecs[v].rdy_rand, -1, 200);
      chk("lead_idle", 32'(n_idle), 32'(vecs[v].exp_idle));
      chk("seq_after", 32'(sq[0]), 32'(vecs[v].exp_seq));
    end

    // Enable dropped while SEQ is presented: frame completes, gap, then idle
    do_reset();
    en[0] = 1'b1;
    push_vec(0);
    run_frames(0, 1'b0, 5, 100);
    for (int i = 0; i < 6; i++) begin rdy[0] = 1'b1; cyc(0); end
    chk("drop_busy", 32'(bsy[0]), 32'd0);
    chk("drop_seq", 32'(sq[0]), 32'd1);
    chk("drop_xfers", 32'(n_xfer), 32'd7);

    // Reset asserted in the payload aborts the frame; next frame restarts at seq 0
    do_reset();
    en[0] = 1'b1;
    push_vec(0);
    for (int i = 0; i < 50 && sb.size() > 3; i++) begin rdy[0] = 1'b1; cyc(0); end
    chk("in_payload", 32'(sb.size()), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vld", 32'(vld[0]), 32'd0);
    chk("rst_busy_seq", 32'({bsy[0], sq[0]}), 32'd0);
    rst = 1'b0;
    sb.delete();
    hold_pend = 1'b0;
    push_vec(0);
    run_frames(0, 1'b0, -1, 100);

    // Back-to-back: 256 frames with seq wrap, no bubbles
    do_reset();
    en[1] = 1'b1;
    for (int s = 0; s < 256; s++) push_model(8'(s), 3);
    run_frames(1, 1'b0, 5, 2500);
    chk("b2b_xfers", 32'(n_xfer), 32'd1792);
    chk("b2b_idle", 32'(n_idle), 32'd1);
    chk("b2b_seq_wrap", 32'(sq[1]), 32'd0);

    // Single-byte payload, back-to-back: start and done never coincide
    do_reset();
    en[2] = 1'b1;
    for (int s = 0; s < 3; s++) push_model(8'(s), 1);
    run_frames(2, 1'b0, 4, 100);
    chk("len1_xfers", 32'(n_xfer), 32'd15);
    chk("len1_coincide", 32'(n_coinc), 32'd0);
    chk("len1_seq", 32'(sq[2]), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_pattern_source.md
STREAM_PATTERN_SOURCE -- requirements
Module: stream_pattern_source

Interface
REQ-001 Parameter FRAME_LEN, default 9, SHALL set payload bytes per frame; legal range 1..255; frame length = FRAME_LEN+4 bytes.
REQ-002 Parameter GAP_CYCLES, default 4999987, SHALL set idle cycles between frames, with tx_vld=0; legal range 0..2^24-1.
REQ-003 Parameter SYNC0, default 8'hA5, SHALL be the first sync byte.
REQ-004 Parameter SYNC1, default 8'h5A, SHALL be the second sync byte.
REQ-005 clk  input  1  fabric clock, 100 MHz; all logic on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  level; permits new frames to start.
REQ-008 tx_rdy  input  1  sink ready; a byte transfers on a cycle with tx_vld=1 and tx_rdy=1.
REQ-009 tx_vld  output  1  registered; tx_byte is valid.
REQ-010 tx_byte  output  8  registered; current stream byte.
REQ-011 frame_start  output  1  one-cycle pulse on the cycle SYNC0 transfers.
REQ-012 frame_done  output  1  one-cycle pulse on the cycle the checksum byte transfers.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 seq  output  8  sequence number of the current or next frame.

Function
REQ-015 Frame byte order SHALL be: SYNC0, SYNC1, SEQ, payload[0..FRAME_LEN-1], CSUM.
REQ-016 payload[i] SHALL equal (seq+i) mod 256.
REQ-017 CSUM SHALL equal seq XOR payload[0] XOR ... XOR payload[FRAME_LEN-1]; sync bytes are excluded.
REQ-018 States SHALL be IDLE, S_SYNC0, S_SYNC1, S_SEQ, S_PAY, S_CSUM, GAP.
REQ-019 tx_vld SHALL be 1 exactly in S_SYNC0..S_CSUM.
REQ-020 tx_byte SHALL be the byte of the current state; in S_PAY it SHALL be the byte at the current payload index.
REQ-021 IDLE SHALL go to S_SYNC0 on the next cycle when enable=1, so the first tx_vld appears 1 cycle after enable is sampled high.
REQ-022 Each S_* state SHALL advance only on a transfer; S_PAY SHALL stay in place until FRAME_LEN transfers, with an 8-bit index counting 0..FRAME_LEN-1.
REQ-023 Once tx_vld=1, tx_vld and tx_byte SHALL hold stable until the transfer occurs; there SHALL be no combinational path from tx_rdy to tx_vld or tx_byte.
REQ-024 The source SHALL support one transfer per cycle when tx_rdy is held high; there SHALL be no bubbles within a frame.
REQ-025 A transfer in S_CSUM SHALL increment seq by 1, wrapping 255 to 0, and SHALL pulse frame_done.
REQ-026 After S_CSUM transfers with GAP_CYCLES>0, the block SHALL enter GAP for exactly GAP_CYCLES cycles with tx_vld=0.
REQ-027 After the gap, the block SHALL go to S_SYNC0 if enable=1, otherwise to IDLE.
REQ-028 With GAP_CYCLES=0, S_CSUM SHALL go directly to S_SYNC0 if enable=1, otherwise to IDLE, so frames run back-to-back.
REQ-029 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame SHALL complete and no new frame SHALL start.
REQ-030 Deasserting enable during GAP SHALL NOT shorten the gap.
REQ-031 frame_start and frame_done SHALL never both be 1 in the same cycle, given FRAME_LEN ≥ 1.
REQ-032 The gap counter SHALL be 24 bits; all byte arithmetic SHALL be modulo 256.

Reset
REQ-033 rst SHALL force state=IDLE, tx_vld=0, tx_byte=0, frame_start=0, frame_done=0, busy=0, seq=0, payload index=0, gap counter=0.
REQ-034 rst SHALL take priority over all other inputs; asserting it mid-frame SHALL abort the frame with no further transfers, and the next frame SHALL restart at seq=0.

Verification (FRAME_LEN=3, GAP_CYCLES=2 unless stated)
REQ-035 rst, then enable=1 and tx_rdy=1 held -> bytes A5 5A 00 00 01 02 03 on 7 consecutive cycles; frame_done pulses on the 03 byte; then 2 cycles with tx_vld=0; then A5 5A 01 01 02 03 01.
REQ-036 tx_rdy toggled pseudo-randomly -> the byte sequence is identical to REQ-035; tx_byte and tx_vld are stable on every cycle where vld=1 and rdy=0.
REQ-037 enable dropped on the SEQ byte of frame 0 -> frame 0 completes (csum 03), then GAP, then IDLE with busy=0 and seq=1.
REQ-038 GAP_CYCLES=0, tx_rdy=1, 256 frames -> 1792 contiguous transfers with no idle cycle; seq wraps 255→0; the frame with seq=255 carries payload FF 00 01 and csum FF^FF^00^01 = 01.
REQ-039 rst asserted while in S_PAY -> tx_vld=0 on the next cycle; after release with enable=1, the next frame is A5 5A 00 ....
REQ-040 FRAME_LEN=1, GAP_CYCLES=0 -> frame A5 5A 00 00 00; frame_start and frame_done never coincide.
